// File: rtl/block_0_apb_bridge.sv
// APB slave to single-outstanding register-request bridge.
// An APB setup phase is turned into one downstream request. The transfer is
// stretched with wait states until the downstream side responds or the
// timeout expires. The result is then returned in one APB access cycle.
module block_0_apb_bridge #(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_psel,
  input  logic                     i_penable,
  input  logic [ADDRESS_WIDTH-1:0] i_paddr,
  input  logic                     i_pwrite,
  input  logic [BUS_WIDTH-1:0]     i_pwdata,
  input  logic [BUS_WIDTH/8-1:0]   i_pstrb,
  output logic                     o_pready,
  output logic [BUS_WIDTH-1:0]     o_prdata,
  output logic                     o_pslverr,
  output logic                     o_req_valid,
  output logic                     o_req_write,
  output logic [ADDRESS_WIDTH-1:0] o_req_address,
  output logic [BUS_WIDTH-1:0]     o_req_write_data,
  output logic [BUS_WIDTH/8-1:0]   o_req_strobe,
  input  logic                     i_rsp_ready,
  input  logic [1:0]               i_rsp_status,
  input  logic [BUS_WIDTH-1:0]     i_rsp_read_data
);

  localparam int STRB_W  = BUS_WIDTH / 8;
  localparam int ALIGN_W = $clog2(STRB_W);
  // A zero timeout still needs a 1-bit counter so the declarations stay legal.
  localparam int CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     tmo_cnt;
  logic                 rsp_err;
  logic [BUS_WIDTH-1:0] rsp_data;

  logic                 apb_setup;
  logic                 misaligned;
  logic [CNT_W-1:0]     tmo_next;
  logic                 tmo_hit;
  logic                 unused_status_lsb;

  assign apb_setup  = i_psel & ~i_penable;
  assign misaligned = |i_paddr[ALIGN_W-1:0];
  assign tmo_next   = tmo_cnt + CNT_W'(1);
  // The expiry check is based on the incremented value, so a response arriving
  // in the same cycle is handled first and wins over the timeout.
  assign tmo_hit    = (TIMEOUT_CYCLES != 0) && (tmo_next == TMO_LIMIT);

  // Only SLVERR/DECERR matter; EXOKAY is treated as OKAY.
  assign unused_status_lsb = i_rsp_status[0];

  // Bridge FSM: capture on setup, hold the request, latch the response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= IDLE;
      tmo_cnt          <= '0;
      rsp_err          <= 1'b0;
      rsp_data         <= '0;
      o_req_valid      <= 1'b0;
      o_req_write      <= 1'b0;
      o_req_address    <= '0;
      o_req_write_data <= '0;
      o_req_strobe     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (apb_setup) begin
            o_req_write      <= i_pwrite;
            o_req_address    <= i_paddr;
            o_req_write_data <= i_pwdata;
            o_req_strobe     <= i_pwrite ? i_pstrb : {STRB_W{1'b1}};
            rsp_data         <= '0;
            tmo_cnt          <= '0;
            if (misaligned) begin
              // Misaligned accesses never reach the register side.
              rsp_err <= 1'b1;
              state   <= RESPOND;
            end else begin
              rsp_err     <= 1'b0;
              o_req_valid <= 1'b1;
              state       <= REQUEST;
            end
          end
        end
        REQUEST: begin
          if (i_rsp_ready) begin
            o_req_valid <= 1'b0;
            rsp_err     <= i_rsp_status[1];
            rsp_data    <= o_req_write ? '0 : i_rsp_read_data;
            state       <= RESPOND;
          end else if (tmo_hit) begin
            o_req_valid <= 1'b0;
            rsp_err     <= 1'b1;
            rsp_data    <= '0;
            state       <= RESPOND;
          end else begin
            tmo_cnt <= tmo_next;
          end
        end
        RESPOND: begin
          // Complete on the access cycle, or discard if the master deselected.
          if (!i_psel || i_penable) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // APB response is only driven during the completing access cycle.
  always_comb begin
    o_pready  = (state == RESPOND) & i_psel & i_penable;
    o_pslverr = o_pready & rsp_err;
    o_prdata  = o_pready ? rsp_data : '0;
  end

endmodule

// File: tb/tb_block_0_apb_bridge.sv
// Directed testbench for block_0_apb_bridge.
module tb_block_0_apb_bridge;

  localparam int AW = 8;
  localparam int BW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic          pwrite = 1'b0;
  logic [BW-1:0] pwdata = '0;
  logic [3:0]    pstrb = '0;
  logic          pready;
  logic [BW-1:0] prdata;
  logic          pslverr;
  logic          req_valid;
  logic          req_write;
  logic [AW-1:0] req_address;
  logic [BW-1:0] req_write_data;
  logic [3:0]    req_strobe;
  logic          rsp_ready = 1'b0;
  logic [1:0]    rsp_status = 2'b00;
  logic [BW-1:0] rsp_read_data = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  block_0_apb_bridge #(
    .ADDRESS_WIDTH (AW),
    .BUS_WIDTH     (BW),
    .TIMEOUT_CYCLES(32)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_psel          (psel),
    .i_penable       (penable),
    .i_paddr         (paddr),
    .i_pwrite        (pwrite),
    .i_pwdata        (pwdata),
    .i_pstrb         (pstrb),
    .o_pready        (pready),
    .o_prdata        (prdata),
    .o_pslverr       (pslverr),
    .o_req_valid     (req_valid),
    .o_req_write     (req_write),
    .o_req_address   (req_address),
    .o_req_write_data(req_write_data),
    .o_req_strobe    (req_strobe),
    .i_rsp_ready     (rsp_ready),
    .i_rsp_status    (rsp_status),
    .i_rsp_read_data (rsp_read_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    psel      = 1'b0;
    penable   = 1'b0;
    rsp_ready = 1'b0;
    cyc();
  endtask

  // One APB transfer starting at posedge+1. rsp_wait = access cycle index at
  // which i_rsp_ready is driven (-1 = never). Returns at posedge+1 after the
  // completing access cycle with psel/penable still high.
  task automatic xfer(input logic [AW-1:0] a, input logic w, input logic [BW-1:0] wd,
                      input logic [3:0] st, input int rsp_wait, input logic [1:0] status,
                      input logic [BW-1:0] rd_in,
                      output logic err, output logic [BW-1:0] rd, output int vcnt,
                      output int acc, output logic [AW-1:0] q_addr, output logic q_write,
                      output logic [BW-1:0] q_wdata, output logic [3:0] q_strb,
                      output logic stable);
    bit done = 0;
    bit seen = 0;
    int k = 0;
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = wd; pstrb = st;
    rsp_status = status; rsp_read_data = rd_in;
    rsp_ready = 1'b1;  // ignored while idle
    err = 1'b0; rd = '0; vcnt = 0; acc = 0; stable = 1'b1;
    q_addr = '0; q_write = 1'b0; q_wdata = '0; q_strb = '0;
    cyc();
    penable = 1'b1;
    while (!done && k < 200) begin
      rsp_ready = (rsp_wait >= 0) && (k == rsp_wait);
      @(negedge clk);
      if (req_valid) begin
        vcnt++;
        if (!seen) begin
          seen = 1; q_addr = req_address; q_write = req_write;
          q_wdata = req_write_data; q_strb = req_strobe;
        end else if (req_address !== q_addr || req_write !== q_write ||
                     req_write_data !== q_wdata || req_strobe !== q_strb) begin
          stable = 1'b0;
        end
      end
      if (pready) begin
        done = 1; err = pslverr; rd = prdata;
      end
      cyc();
      k++;
    end
    acc = k;
    rsp_ready = 1'b0;
    if (!done) check("xfer_completed", 0, 1);
  endtask

  logic          e;
  logic [BW-1:0] r;
  int            vc, ac;
  logic [AW-1:0] qa;
  logic          qw;
  logic [BW-1:0] qd;
  logic [3:0]    qs;
  logic          stb;

  initial begin
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pready", pready, 0);
    check("rst_pslverr", pslverr, 0);
    check("rst_prdata", prdata, 0);
    check("rst_req_valid", req_valid, 0);
    check("rst_req_write", req_write, 0);
    check("rst_req_address", req_address, 0);
    check("rst_req_wdata", req_write_data, 0);
    check("rst_req_strobe", req_strobe, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Write 0x04, response in first access cycle.
    xfer(8'h04, 1, 32'h0000_0001, 4'hF, 0, 2'b00, 32'hDEAD_BEEF, e, r, vc, ac, qa, qw, qd, qs, stb);
    check("wr_valid_cycles", vc, 1);
    check("wr_access_cycles", ac, 2);
    check("wr_req_address", qa, 8'h04);
    check("wr_req_write", qw, 1);
    check("wr_req_wdata", qd, 32'h1);
    check("wr_req_strobe", qs, 4'hF);
    check("wr_pslverr", e, 0);
    check("wr_prdata_zero", r, 0);
    go_idle();

    // Read 0x28, response after 5 wait cycles; read strobe forced to all-ones.
    xfer(8'h28, 0, 32'h0, 4'h3, 5, 2'b00, 32'h0000_0A5A, e, r, vc, ac, qa, qw, qd, qs, stb);
    check("rd_valid_cycles", vc, 6);
    check("rd_access_cycles", ac, 7);
    check("rd_req_strobe", qs, 4'hF);
    check("rd_req_write", qw, 0);
    check("rd_req_stable", stb, 1);
    check("rd_prdata", r, 32'h0000_0A5A);
    check("rd_pslverr", e, 0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("rd_prdata_after", prdata, 0);
    check("rd_pready_after", pready, 0);
    cyc();

    // Misaligned read: no downstream request, error response.
    xfer(8'h02, 0, 32'h0, 4'hF, 0, 2'b00, 32'h1111_2222, e, r, vc, ac, qa, qw, qd, qs, stb);
    check("mis_valid_cycles", vc, 0);
    check("mis_pslverr", e, 1);
    check("mis_prdata", r, 0);
    go_idle();

    // Timeout: request held exactly 32 cycles, then error.
    xfer(8'h30, 0, 32'h0, 4'hF, -1, 2'b00, 32'h7777_7777, e, r, vc, ac, qa, qw, qd, qs, stb);
    check("tmo_valid_cycles", vc, 32);
    check("tmo_req_stable", stb, 1);
    check("tmo_pslverr", e, 1);
    check("tmo_prdata", r, 0);
    go_idle();

    // Response on the expiring cycle wins.
    xfer(8'h30, 0, 32'h0, 4'hF, 31, 2'b00, 32'h7777_7777, e, r, vc, ac, qa, qw, qd, qs, stb);
    check("edge_valid_cycles", vc, 32);
    check("edge_pslverr", e, 0);
    check("edge_prdata", r, 32'h7777_7777);
    go_idle();

    // Write with SLVERR, then back-to-back read of 0x00 with OKAY.
    xfer(8'h08, 1, 32'hCAFE_0000, 4'h5, 0, 2'b10, 32'h9999_9999, e, r, vc, ac, qa, qw, qd, qs, stb);
    check("b2b_wr_pslverr", e, 1);
    check("b2b_wr_prdata", r, 0);
    check("b2b_wr_strobe", qs, 4'h5);
    xfer(8'h00, 0, 32'h0, 4'h0, 0, 2'b00, 32'h0BAD_F00D, e, r, vc, ac, qa, qw, qd, qs, stb);
    check("b2b_rd_pslverr", e, 0);
    check("b2b_rd_valid_cycles", vc, 1);
    check("b2b_rd_access_cycles", ac, 2);
    check("b2b_rd_prdata", r, 32'h0BAD_F00D);
    // DECERR and EXOKAY status decoding, also back-to-back.
    xfer(8'h0C, 0, 32'h0, 4'h0, 1, 2'b11, 32'h1234_5678, e, r, vc, ac, qa, qw, qd, qs, stb);
    check("decerr_pslverr", e, 1);
    xfer(8'h0C, 0, 32'h0, 4'h0, 1, 2'b01, 32'h1234_5678, e, r, vc, ac, qa, qw, qd, qs, stb);
    check("exokay_pslverr", e, 0);
    check("exokay_prdata", r, 32'h1234_5678);
    go_idle();

    // Deselect while responding discards the transfer.
    psel = 1'b1; penable = 1'b0; paddr = 8'h08; pwrite = 1'b0; rsp_read_data = 32'hABCD_0001;
    rsp_status = 2'b00;
    cyc();
    penable = 1'b1; rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("abort_pready", pready, 0);
    check("abort_prdata", prdata, 0);
    cyc();
    xfer(8'h14, 0, 32'h0, 4'h0, 0, 2'b00, 32'h0000_0055, e, r, vc, ac, qa, qw, qd, qs, stb);
    check("post_abort_access", ac, 2);
    check("post_abort_prdata", r, 32'h55);
    go_idle();

    // Reset in the third REQUEST cycle.
    psel = 1'b1; penable = 1'b0; paddr = 8'h10; pwrite = 1'b0; rsp_ready = 1'b0;
    cyc();
    penable = 1'b1;
    cyc();
    cyc();
    check("rstmid_valid_before", req_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_valid_async", req_valid, 0);
    check("rstmid_pready", pready, 0);
    cyc();
    rst_n = 1'b1; psel = 1'b0; penable = 1'b0;
    cyc();
    @(negedge clk);
    check("rstmid_idle_valid", req_valid, 0);
    cyc();
    xfer(8'h0C, 0, 32'h0, 4'h0, 1, 2'b00, 32'h0000_1234, e, r, vc, ac, qa, qw, qd, qs, stb);
    check("rstmid_next_valid_cycles", vc, 2);
    check("rstmid_next_prdata", r, 32'h1234);
    check("rstmid_next_pslverr", e, 0);
    go_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
